// File: rtl/des_block_loader_if.sv
// Beat-in / block-out handshake bundle for the DES block loader.
// The slave modport is the loader's view; master is the driving/consuming side.
interface des_block_loader_if #(
  parameter int IN_W = 8
);
  logic            i_Valid;
  logic            o_Ready;
  logic [IN_W-1:0] i_Data;
  logic            i_Last;
  logic            i_Decrypt;
  logic            o_Valid;
  logic            i_Ready;
  logic [63:0]     o_Data;
  logic            o_Decrypt;
  logic [1:0]      o_Level;
  logic            o_Err;

  modport slave (
    input  i_Valid, i_Data, i_Last, i_Decrypt, i_Ready,
    output o_Ready, o_Valid, o_Data, o_Decrypt, o_Level, o_Err
  );

  modport master (
    output i_Valid, i_Data, i_Last, i_Decrypt, i_Ready,
    input  o_Ready, o_Valid, o_Data, o_Decrypt, o_Level, o_Err
  );
endinterface

// File: rtl/des_block_loader.sv
// Packs IN_W-bit beats (first beat MSB) into tagged 64-bit DES blocks and queues them in a small FIFO.
// Optional PKCS#5 message-end padding is enabled by defining DES_LOADER_PAD_EN.
module des_block_loader #(
  parameter int IN_W  = 8,
  parameter int DEPTH = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  des_block_loader_if.slave  bus
);
  localparam int         BEATS     = 64 / IN_W;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
  localparam logic [1:0] LAST_SLOT = 2'(DEPTH - 1);
  localparam logic [1:0] DEPTH_L   = 2'(DEPTH);

  typedef enum logic {FILL, PAD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] asm_q, asm_d;
  logic        tag_q, tag_d;
  logic [1:0]  wr_q, wr_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  level_q, level_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [4];
  logic        mem_tag_q [4];

  logic        ready, accept, pop, push, push_tag, beat_tag;
  logic [63:0] push_data, blk_w;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef DES_LOADER_PAD_EN
  // Bytes at index nbytes..7 take the PKCS#5 pad value 8-nbytes.
  function automatic logic [63:0] pad_block(input logic [63:0] blk, input logic [3:0] nbytes);
    logic [63:0] r;
    r = blk;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) >= nbytes) r[63-8*b -: 8] = 8'(4'd8 - nbytes);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    tag_d     = tag_q;
    err_d     = 1'b0;
    push      = 1'b0;
    ready     = (state_q == FILL) && (level_q < DEPTH_L) && !i_Rst;
    accept    = bus.i_Valid && ready;
    pop       = (level_q != 2'd0) && bus.i_Ready;
    blk_w     = asm_q;
    blk_w[63 - int'(cnt_q)*IN_W -: IN_W] = bus.i_Data;
    beat_tag  = (cnt_q == 3'd0) ? bus.i_Decrypt : tag_q;
    push_data = blk_w;
    push_tag  = beat_tag;

    if (accept) begin
      asm_d = blk_w;
      tag_d = beat_tag;
      if (cnt_q == LAST_BEAT) begin
        push  = 1'b1;
        cnt_d = 3'd0;
`ifdef DES_LOADER_PAD_EN
        if (bus.i_Last) state_d = PAD;
`endif
      end else if (bus.i_Last) begin
        cnt_d = 3'd0;
`ifdef DES_LOADER_PAD_EN
        push      = 1'b1;
        push_data = pad_block(blk_w, 4'((int'(cnt_q) + 1) * IN_W / 8));
`else
        err_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end

`ifdef DES_LOADER_PAD_EN
    // A full final block is followed by a whole block of padding once there is room.
    if (state_q == PAD && level_q < DEPTH_L) begin
      push      = 1'b1;
      push_data = 64'h0808080808080808;
      push_tag  = tag_q;
      state_d   = FILL;
    end
`endif

    wr_d    = push ? ptr_inc(wr_q) : wr_q;
    rd_d    = pop  ? ptr_inc(rd_q) : rd_q;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 2'd1;
    else if (!push && pop) level_d = level_q - 2'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= FILL;
      cnt_q   <= 3'd0;
      asm_q   <= 64'd0;
      tag_q   <= 1'b0;
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      level_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      tag_q   <= tag_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // FIFO storage carries data only; emptiness is tracked by level_q.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem_q[wr_q]     <= push_data;
      mem_tag_q[wr_q] <= push_tag;
    end
  end

  assign bus.o_Ready   = ready;
  assign bus.o_Valid   = (level_q != 2'd0);
  assign bus.o_Data    = (level_q != 2'd0) ? mem_q[rd_q] : 64'd0;
  assign bus.o_Decrypt = (level_q != 2'd0) ? mem_tag_q[rd_q] : 1'b0;
  assign bus.o_Level   = level_q;
  assign bus.o_Err     = err_q;
endmodule

// File: doc/des_block_loader.md
Name: des_block_loader

Overview:
Input front end of the DES datapath, directly upstream of the initial-permutation stage. It accepts plaintext or ciphertext as a stream of IN_W-bit beats with a valid/ready handshake and packs them into 64-bit blocks, first beat most significant. Each block is tagged with its encrypt/decrypt mode. Completed blocks are buffered in a small FIFO and presented to the IP/round core with a valid/ready handshake.

Parameters:
IN_W, 8, input beat width in bits; legal values 8, 16, 32; BEATS = 64/IN_W.
DEPTH, 2, output FIFO entries in blocks; legal range 1..3.

Ports:
i_Clk  in  1  clock; all logic on rising edge.
i_Rst  in  1  synchronous reset, active-high.
i_Valid  in  1  input beat valid.
o_Ready  out  1  loader can accept a beat.
i_Data  in  IN_W  input beat; first beat of a block lands in bits 63:64-IN_W.
i_Last  in  1  final beat of the message; qualified by i_Valid.
i_Decrypt  in  1  mode for the block; sampled on the block's first beat only.
o_Valid  out  1  FIFO head holds a block.
i_Ready  in  1  downstream accepts the block.
o_Data  out  64  FIFO head block; feeds IP input directly.
o_Decrypt  out  1  mode tag of the head block.
o_Level  out  2  number of blocks in the FIFO, 0..DEPTH.
o_Err  out  1  one-cycle pulse: short final block dropped.

Behaviour:
- Interface: one clock, i_Clk. Reset i_Rst is synchronous and active-high.
- Reset clears:
  - beat counter = 0, state = FILL, assembly register = 0, FIFO empty.
  - o_Valid = 0, o_Data = 0, o_Decrypt = 0, o_Level = 0, o_Err = 0.
  - o_Ready = 0 while i_Rst is high.
- Reset mid-block discards the partial block and all FIFO contents.
- Input handshake: beat accepted iff i_Valid && o_Ready.
  - o_Ready = (state == FILL) && (o_Level < DEPTH) && !i_Rst.
  - o_Ready has no combinational path from i_Ready.
- Beat counter runs 0..BEATS-1 and wraps to 0 after the final beat of each block.
  - Each beat lands in its slot of the assembly register.
  - i_Decrypt is captured when the counter is 0.
- Block complete: beat accepted with counter == BEATS-1.
  - Block and its tag are pushed into the FIFO in the same edge.
  - o_Valid rises the next cycle (latency 1 from final-beat acceptance).
- Output handshake: pop iff o_Valid && i_Ready.
  - o_Data/o_Decrypt always reflect the head entry and hold stable while o_Valid && !i_Ready.
- FIFO:
  - Simultaneous push and pop: o_Level unchanged, order preserved.
  - Push while full cannot occur because o_Ready is low.
  - Pop when empty is ignored.
  - Read and write pointers wrap modulo DEPTH.
- i_Last on a full-length final beat: normal push; counter returns to 0.
- i_Last with counter < BEATS-1 (short block), feature disabled:
  - Partial block is discarded; nothing is pushed.
  - o_Err = 1 for exactly one cycle after the accept edge.
  - Counter returns to 0.
- States:
  - FILL: normal operation.
  - PAD: entered only when the optional feature is enabled. o_Ready = 0. When o_Level < DEPTH, pushes the pad block, then returns to FILL.

Optional Feature:
DES_LOADER_PAD_EN
- Enabled: PKCS#5 padding is applied at message end. Let n = bytes already accepted in the current block, counted in bytes.
  - i_Last on a short block: the remaining 8-n bytes are filled with value 8-n, and the block is pushed on the same edge with the tag captured at beat 0. No o_Err.
  - i_Last on a full block: the block is pushed, then the FSM enters PAD and emits 0x0808080808080808, tagged with the last captured mode.
- Disabled: no PAD state; short blocks are dropped with o_Err as specified under Behaviour.

Test Plan:
- IN_W=8, i_Ready=1, bytes 01,23,45,67,89,AB,CD,EF with i_Decrypt=0 on the first byte -> o_Valid high one cycle after byte EF, o_Data=0x0123456789ABCDEF, o_Decrypt=0, o_Level back to 0 after the pop.
- i_Ready=0, DEPTH=2, three back-to-back blocks 0x1111111111111111, 0x2222222222222222, 0x3333333333333333 -> o_Ready drops after the second block's last beat, o_Level=2. Raising i_Ready pops 0x11..., then 0x22.... o_Ready re-asserts and the third block then completes and is delivered in order.
- Mode tagging: first block i_Decrypt=1 on byte 0 and toggling on later beats; second block i_Decrypt=0 -> o_Decrypt=1 then 0.
- Feature off: bytes AA,BB,CC with i_Last on CC -> no push, o_Err one-cycle pulse, o_Level=0. Next 8 bytes form a correct block starting from beat 0.
- Feature on: bytes AA,BB,CC with i_Last -> o_Data=0xAABBCC0505050505. Full block with i_Last -> data block followed by 0x0808080808080808, with o_Ready low during PAD.
- Assert i_Rst after 5 of 8 bytes with one block in the FIFO -> o_Valid=0, o_Level=0 next cycle. A fresh 8-byte block then yields exactly that block.
